// File: rtl/input_fm_load_ctrl_pkg.sv
// Shared definitions for the tile load controllers (input_fm, weight, output).
// Holds the controller state encoding and a counter width helper.
package input_fm_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_READY = 3'd4
    } ctrl_state_t;

    // Bits needed to count 0..bound-1, never less than one bit.
    function automatic int cnt_width(input int bound);
        return (bound > 1) ? $clog2(bound) : 1;
    endfunction

endpackage

// File: rtl/input_fm_tile_addr_gen.sv
// Cascaded col/row/ch counters for a channel-major tile stream, plus a
// bank select counter that steps once per completed channel and wraps at X,
// so the bank index is ch % X without a divider.
module input_fm_tile_addr_gen
    import input_fm_load_ctrl_pkg::*;
#(
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int X  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    advance,
    output logic                    last,
    output logic [cnt_width(X)-1:0] bank_sel
);

    localparam int CW = cnt_width(Tc);
    localparam int RW = cnt_width(Tr);
    localparam int HW = cnt_width(Tm);
    localparam int BW = cnt_width(X);

    localparam logic [CW-1:0] COL_MAX  = CW'(Tc - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(Tr - 1);
    localparam logic [HW-1:0] CH_MAX   = HW'(Tm - 1);
    localparam logic [BW-1:0] BANK_MAX = BW'(X - 1);

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic [HW-1:0] ch_reg;
    logic [BW-1:0] bank_reg;

    logic col_wrap;
    logic row_wrap;

    assign col_wrap = (col_reg == COL_MAX);
    assign row_wrap = (row_reg == ROW_MAX);
    assign last     = col_wrap && row_wrap && (ch_reg == CH_MAX);
    assign bank_sel = bank_reg;

    // Advance col, carrying into row, then into ch and the bank select.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col_reg  <= '0;
            row_reg  <= '0;
            ch_reg   <= '0;
            bank_reg <= '0;
        end else if (advance) begin
            if (col_wrap) begin
                col_reg <= '0;
                if (row_wrap) begin
                    row_reg  <= '0;
                    ch_reg   <= (ch_reg == CH_MAX) ? '0 : ch_reg + 1'b1;
                    bank_reg <= (bank_reg == BANK_MAX) ? '0 : bank_reg + 1'b1;
                end else begin
                    row_reg <= row_reg + 1'b1;
                end
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_fm_load_ctrl.sv
// Input feature-map tile loader: clears the bank write counters, steers the
// channel-major word stream one-hot to bank ch % X, then holds the tile as
// ready until the compute engine releases it.
// Optional stall counter enabled by defining INPUT_FM_LOAD_CTRL_PERF_EN.
// Tm must be a multiple of X so the bank select wraps with the tile.
module input_fm_load_ctrl
    import input_fm_load_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int X  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] wr_data,
    output logic [X-1:0]  wr_ena,
    output logic          conv_tile_reset,
    output logic          load_done,
    output logic          tile_ready,
    input  logic          tile_release
`ifdef INPUT_FM_LOAD_CTRL_PERF_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam int BW = cnt_width(X);

    ctrl_state_t   state_reg;
    ctrl_state_t   state_next;
    logic          accept;
    logic          last;
    logic [BW-1:0] bank_sel;
    logic          addr_clear;
    logic [X-1:0]  wr_ena_next;
    logic [X-1:0]  wr_ena_reg;
    logic [DW-1:0] wr_data_reg;

    // in_ready is a pure state decode, so accept has no path from in_valid to in_ready.
    assign accept     = in_ready && in_valid;
    assign addr_clear = (state_reg == ST_CLR) || (accept && last);

    input_fm_tile_addr_gen #(
        .Tm (Tm),
        .Tr (Tr),
        .Tc (Tc),
        .X  (X)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (addr_clear),
        .advance  (accept),
        .last     (last),
        .bank_sel (bank_sel)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and state-decoded outputs; start and tile_release only count in their own state.
    always_comb begin
        state_next      = state_reg;
        busy            = 1'b1;
        in_ready        = 1'b0;
        conv_tile_reset = 1'b0;
        load_done       = 1'b0;
        tile_ready      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                conv_tile_reset = 1'b1;
                state_next      = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                load_done  = 1'b1;
                state_next = ST_READY;
            end
            ST_READY: begin
                tile_ready = 1'b1;
                if (tile_release) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One-hot bank enable decode from the bank select counter.
    genvar gi;
    generate
        for (gi = 0; gi < X; gi++) begin : g_bank_en
            assign wr_ena_next[gi] = accept && (bank_sel == BW'(gi));
        end
    endgenerate

    // Registered broadcast write port; data holds between accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ena_reg  <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_ena_reg <= wr_ena_next;
            if (accept) begin
                wr_data_reg <= in_data;
            end
        end
    end

    assign wr_ena  = wr_ena_reg;
    assign wr_data = wr_data_reg;

`ifdef INPUT_FM_LOAD_CTRL_PERF_EN
    logic [31:0] stall_cnt_reg;

    // Saturating count of LOAD cycles starved of input; restarts with each tile.
    always_ff @(posedge clk) begin
        if (rst || (state_reg == ST_CLR)) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_LOAD) && !in_valid && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_input_fm_load_ctrl.sv
// Self-checking bench for input_fm_load_ctrl (Tm=4, Tr=2, Tc=2, X=2).
// A word-count based model predicts outputs every cycle; directed literal
// checks pin latencies and bank contents.
`timescale 1ns/1ps
module tb_input_fm_load_ctrl;

    localparam int DW    = 32;
    localparam int Tm    = 4;
    localparam int Tr    = 2;
    localparam int Tc    = 2;
    localparam int X     = 2;
    localparam int WPC   = Tr * Tc;
    localparam int N     = Tm * WPC;
    localparam int DEPTH = N / X;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] wr_data;
    logic [X-1:0]  wr_ena;
    logic          conv_tile_reset;
    logic          load_done;
    logic          tile_ready;
    logic          tile_release;
`ifdef INPUT_FM_LOAD_CTRL_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    input_fm_load_ctrl #(
        .DW (DW), .Tm (Tm), .Tr (Tr), .Tc (Tc), .X (X)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .wr_data         (wr_data),
        .wr_ena          (wr_ena),
        .conv_tile_reset (conv_tile_reset),
        .load_done       (load_done),
        .tile_ready      (tile_ready),
        .tile_release    (tile_release)
`ifdef INPUT_FM_LOAD_CTRL_PERF_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_CLR, M_LOAD, M_FLUSH, M_READY} mphase_t;
    mphase_t       m_phase   = M_IDLE;
    int            m_cnt     = 0;
    logic [X-1:0]  m_wr_ena  = '0;
    logic [DW-1:0] m_wr_data = '0;
    logic [31:0]   m_stall   = '0;
    int            cyc       = 0;
    bit            checking  = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase   = M_IDLE;
                m_cnt     = 0;
                m_wr_ena  = '0;
                m_wr_data = '0;
                m_stall   = '0;
            end else begin
                m_wr_ena = '0;
                if (m_phase == M_LOAD && in_valid) begin
                    // word index -> channel -> bank
                    m_wr_ena[(m_cnt / WPC) % X] = 1'b1;
                    m_wr_data = in_data;
                end
                case (m_phase)
                    M_IDLE:  if (start) m_phase = M_CLR;
                    M_CLR: begin
                        m_phase = M_LOAD;
                        m_stall = '0;
                    end
                    M_LOAD: begin
                        if (in_valid) begin
                            m_cnt++;
                            if (m_cnt == N) begin
                                m_cnt   = 0;
                                m_phase = M_FLUSH;
                            end
                        end else if (m_stall != 32'hFFFF_FFFF) begin
                            m_stall++;
                        end
                    end
                    M_FLUSH: m_phase = M_READY;
                    M_READY: if (tile_release) m_phase = M_IDLE;
                    default: m_phase = M_IDLE;
                endcase
            end
            cyc++;
            checking = 1;
        end
    end

    // ---------------- per-cycle compare + bank capture ----------------
    logic [DW-1:0] mem [X][DEPTH];
    int            ptr [X];
    int            clr_cnt      = 0;
    int            ld_cyc       = 0;
    int            last_acc_cyc = 0;

    initial begin
        for (int b = 0; b < X; b++) ptr[b] = 0;
        forever begin
            @(negedge clk);
            if (checking) begin
                chk("busy",            busy,            m_phase != M_IDLE);
                chk("in_ready",        in_ready,        m_phase == M_LOAD);
                chk("conv_tile_reset", conv_tile_reset, m_phase == M_CLR);
                chk("load_done",       load_done,       m_phase == M_FLUSH);
                chk("tile_ready",      tile_ready,      m_phase == M_READY);
                chk("wr_ena",          wr_ena,          m_wr_ena);
                chk("wr_data",         wr_data,         m_wr_data);
`ifdef INPUT_FM_LOAD_CTRL_PERF_EN
                chk("stall_cnt",       stall_cnt,       m_stall);
`endif
                if (conv_tile_reset) begin
                    clr_cnt++;
                    for (int b = 0; b < X; b++) ptr[b] = 0;
                end
                if (load_done) ld_cyc = cyc;
                for (int b = 0; b < X; b++) begin
                    if (wr_ena[b] && ptr[b] < DEPTH) begin
                        mem[b][ptr[b]] = wr_data;
                        $display("write bank %0d addr %0d data %0h", b, ptr[b], wr_data);
                        ptr[b]++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int base, input int nwords, input bit toggle, input int poke);
        int idx;
        int guard;
        bit tog;
        bit acc;
        idx = 0; guard = 0; tog = 1'b1;
        while (idx < nwords && guard < 400) begin
            in_valid     = toggle ? tog : 1'b1;
            in_data      = DW'(base + idx);
            start        = (guard == poke);
            tile_release = (guard == poke);
            @(negedge clk);
            acc = in_ready && in_valid;
            if (acc) last_acc_cyc = cyc;
            tick();
            if (acc) idx++;
            tog = !tog;
            guard++;
        end
        in_valid = 1'b0; start = 1'b0; tile_release = 1'b0;
        chk("stream_words_accepted", idx, nwords);
    endtask

    task automatic wait_ready(output int r);
        int g;
        g = 0;
        while (!tile_ready && g < 100) begin
            tick();
            g++;
        end
        r = cyc;
        chk("tile_ready_seen", tile_ready, 1);
    endtask

    task automatic check_banks(input string tag, input int base);
        for (int b = 0; b < X; b++) begin
            chk({tag, "_bank_fill"}, ptr[b], DEPTH);
            for (int n = 0; n < DEPTH; n++) begin
                // nth word of bank b comes from channel b + X*(n/WPC)
                chk({tag, "_bank_word"}, mem[b][n],
                    DW'(base + (b + X * (n / WPC)) * WPC + n % WPC));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_in_ready"},   in_ready, 0);
        chk({tag, "_wr_ena"},     wr_ena, 0);
        chk({tag, "_wr_data"},    wr_data, 0);
        chk({tag, "_ctr"},        conv_tile_reset, 0);
        chk({tag, "_load_done"},  load_done, 0);
        chk({tag, "_tile_ready"}, tile_ready, 0);
`ifdef INPUT_FM_LOAD_CTRL_PERF_EN
        chk({tag, "_stall_cnt"},  stall_cnt, 0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        int r;
        int clr0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; tile_release = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Tile A: continuous stream of words 0..15
        clr0 = clr_cnt;
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        stream(0, N, 1'b0, -1);
        wait_ready(r);
        chk("tileA_start_to_ready", r - s, 19);
        chk("tileA_load_done_lag", ld_cyc - last_acc_cyc, 1);
        chk("tileA_clr_pulses", clr_cnt - clr0, 1);
        check_banks("tileA", 0);
        chk("tileA_bank0_addr4", mem[0][4], 8);
        chk("tileA_bank1_addr0", mem[1][0], 4);
        chk("tileA_bank1_addr7", mem[1][7], 15);
        tile_release = 1'b1;
        tick();
        tile_release = 1'b0;
        chk("tileA_release_busy", busy, 0);

        // Tile B: in_valid toggling, start/tile_release poked during LOAD
        clr0 = clr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stream(256, N, 1'b1, 3);
        wait_ready(r);
        chk("tileB_clr_pulses", clr_cnt - clr0, 1);
        check_banks("tileB", 256);
`ifdef INPUT_FM_LOAD_CTRL_PERF_EN
        chk("tileB_stall_cnt", stall_cnt, 15);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_start_ignored_tile_ready", tile_ready, 1);
        tick();
        chk("ready_start_ignored_ctr", conv_tile_reset, 0);
        start = 1'b1; tile_release = 1'b1;
        tick();
        start = 1'b0; tile_release = 1'b0;
        chk("start_with_release_busy", busy, 0);
        tick();
        chk("start_with_release_no_clr", conv_tile_reset, 0);
        chk("tileB_total_clr", clr_cnt - clr0, 1);

        // Tile C: reset after word 5
        start = 1'b1;
        tick();
        start = 1'b0;
        stream(512, 6, 1'b0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midload_reset");

        // Tile D: fresh load after the abandoned one
        start = 1'b1; s = cyc;
        tick();
        start = 1'b0;
        stream(0, N, 1'b0, -1);
        wait_ready(r);
        chk("tileD_start_to_ready", r - s, 19);
        check_banks("tileD", 0);
        chk("tileD_bank0_addr0", mem[0][0], 0);
        chk("tileD_bank0_addr1", mem[0][1], 1);
        tile_release = 1'b1;
        tick();
        tile_release = 1'b0;
        chk("tileD_release_busy", busy, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
